// File: rtl/ceespu_gpu_pkg.sv
// Shared GPU constants: default parameter widths and the reset-time 16-colour palette.
package ceespu_gpu_pkg;

  localparam int unsigned DEF_INDEX_W = 4;
  localparam int unsigned DEF_CH_W    = 8;
  localparam int unsigned DEF_FADE_W  = 4;

  // Packed {R,G,B} entries, index 15 in the MSBs down to index 0 in the LSBs.
  localparam logic [15:0][23:0] DEFAULT_PALETTE = {
    24'hDEEED6, 24'hDAD45E, 24'h6DC2CA, 24'hD2AA99,
    24'h6DAA2C, 24'h8595A1, 24'hD27D2C, 24'h597DCE,
    24'h757161, 24'hD04648, 24'h346524, 24'h854C30,
    24'h4E4A4E, 24'h30346D, 24'h442434, 24'h140C1C
  };

  // Narrow an 8-bit default channel to ch_w bits by dropping LSBs.
  function automatic logic [7:0] reduce_channel(input logic [7:0] v, input int unsigned ch_w);
    return v >> (8 - ch_w);
  endfunction

endpackage

// File: rtl/ceespu_fade_scale.sv
// One colour channel of the brightness stage: registered (c*(F+1))>>FADE_W, or black when cleared.
module ceespu_fade_scale
  import ceespu_gpu_pkg::*;
#(
  parameter int unsigned CH_W   = DEF_CH_W,
  parameter int unsigned FADE_W = DEF_FADE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH_W-1:0]   chan,
  input  logic [FADE_W-1:0] fade,
  input  logic              clear,
  output logic [CH_W-1:0]   scaled
);

  localparam int unsigned PROD_W = CH_W + FADE_W + 1;

  logic [FADE_W:0]   gain_c;
  logic [PROD_W-1:0] prod_c;

  // (F+1) never exceeds 2**FADE_W, so the shifted product always fits in CH_W.
  assign gain_c = {1'b0, fade} + (FADE_W + 1)'(1);
  assign prod_c = PROD_W'(chan) * PROD_W'(gain_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scaled <= '0;
    end else if (clear) begin
      scaled <= '0;
    end else begin
      scaled <= CH_W'(prod_c >> FADE_W);
    end
  end

endmodule

// File: rtl/ceespu_palette_ram.sv
// CPU-programmable colour lookup table with a 2-stage pixel path (lookup, then fade/blank)
// and a 1-cycle readback port. All reads are read-first against a same-cycle write.
module ceespu_palette_ram
  import ceespu_gpu_pkg::*;
#(
  parameter int unsigned INDEX_W = DEF_INDEX_W,
  parameter int unsigned CH_W    = DEF_CH_W,
  parameter int unsigned FADE_W  = DEF_FADE_W
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  input  logic                I_pix_valid,
  input  logic [INDEX_W-1:0]  I_pix_index,
  input  logic                I_blank,
  input  logic [FADE_W-1:0]   I_fade,
  input  logic                I_wr_en,
  input  logic [INDEX_W-1:0]  I_wr_addr,
  input  logic [3*CH_W-1:0]   I_wr_data,
  input  logic                I_rd_en,
  input  logic [INDEX_W-1:0]  I_rd_addr,
  output logic [3*CH_W-1:0]   O_rd_data,
  output logic                O_rd_valid,
  output logic [CH_W-1:0]     O_red,
  output logic [CH_W-1:0]     O_green,
  output logic [CH_W-1:0]     O_blue,
  output logic                O_pix_valid
);

  localparam int unsigned DEPTH  = 1 << INDEX_W;
  localparam int unsigned DATA_W = 3 * CH_W;

  // Default entry for table slot i, wrapping the 16-entry palette over deeper tables.
  function automatic logic [DATA_W-1:0] default_entry(input int unsigned i);
    logic [23:0] e;
    e = DEFAULT_PALETTE[4'(i)];
    return {CH_W'(reduce_channel(e[23:16], CH_W)),
            CH_W'(reduce_channel(e[15:8],  CH_W)),
            CH_W'(reduce_channel(e[7:0],   CH_W))};
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] s1_data;
  logic              s1_blank;
  logic              s1_valid;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[INDEX_W'(i)] <= default_entry(i);
      end
    end else if (I_wr_en) begin
      mem[I_wr_addr] <= I_wr_data;
    end
  end

  // CPU readback; data holds between strobes.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_rd_data  <= '0;
      O_rd_valid <= 1'b0;
    end else begin
      O_rd_valid <= I_rd_en;
      if (I_rd_en) begin
        O_rd_data <= mem[I_rd_addr];
      end
    end
  end

  // Stage 1: table lookup; data registers update every cycle regardless of valid.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      s1_data  <= '0;
      s1_blank <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      s1_data  <= mem[I_pix_index];
      s1_blank <= I_blank;
      s1_valid <= I_pix_valid;
    end
  end

  // Stage 2: fade and blank per channel, fade sampled live rather than piped.
  ceespu_fade_scale #(.CH_W(CH_W), .FADE_W(FADE_W)) u_fade_red (
    .clk    (I_clk),
    .rst_n  (I_rst_n),
    .chan   (s1_data[3*CH_W-1:2*CH_W]),
    .fade   (I_fade),
    .clear  (s1_blank),
    .scaled (O_red)
  );

  ceespu_fade_scale #(.CH_W(CH_W), .FADE_W(FADE_W)) u_fade_green (
    .clk    (I_clk),
    .rst_n  (I_rst_n),
    .chan   (s1_data[2*CH_W-1:CH_W]),
    .fade   (I_fade),
    .clear  (s1_blank),
    .scaled (O_green)
  );

  ceespu_fade_scale #(.CH_W(CH_W), .FADE_W(FADE_W)) u_fade_blue (
    .clk    (I_clk),
    .rst_n  (I_rst_n),
    .chan   (s1_data[CH_W-1:0]),
    .fade   (I_fade),
    .clear  (s1_blank),
    .scaled (O_blue)
  );

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_pix_valid <= 1'b0;
    end else begin
      O_pix_valid <= s1_valid;
    end
  end

endmodule

// File: tb/tb_ceespu_palette_ram.sv
// Directed bench for ceespu_palette_ram: streamed lookup table plus write/readback/reset sequences.
module tb_ceespu_palette_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_valid;
  logic [3:0]  pix_index;
  logic        blank;
  logic [3:0]  fade;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [23:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [23:0] rd_data;
  logic        rd_valid;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        out_valid;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  ceespu_palette_ram #(.INDEX_W(4), .CH_W(8), .FADE_W(4)) dut (
    .I_clk       (clk),
    .I_rst_n     (rst_n),
    .I_pix_valid (pix_valid),
    .I_pix_index (pix_index),
    .I_blank     (blank),
    .I_fade      (fade),
    .I_wr_en     (wr_en),
    .I_wr_addr   (wr_addr),
    .I_wr_data   (wr_data),
    .I_rd_en     (rd_en),
    .I_rd_addr   (rd_addr),
    .O_rd_data   (rd_data),
    .O_rd_valid  (rd_valid),
    .O_red       (red),
    .O_green     (green),
    .O_blue      (blue),
    .O_pix_valid (out_valid)
  );

  typedef struct {
    logic [3:0]  index;
    logic        blank;
    logic [3:0]  fade;
    logic [23:0] exp_rgb;
  } vec_t;

  localparam int N = 19;
  vec_t        vecs [N];
  logic [23:0] pal  [16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] pix_word();
    return {7'd0, out_valid, red, green, blue};
  endfunction

  function automatic logic [31:0] rd_word();
    return {7'd0, rd_valid, rd_data};
  endfunction

  initial begin
    pal = '{24'h140C1C, 24'h442434, 24'h30346D, 24'h4E4A4E,
            24'h854C30, 24'h346524, 24'hD04648, 24'h757161,
            24'h597DCE, 24'hD27D2C, 24'h8595A1, 24'h6DAA2C,
            24'hD2AA99, 24'h6DC2CA, 24'hDAD45E, 24'hDEEED6};
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{4'(i), (i == 9), 4'd15, (i == 9) ? 24'h000000 : pal[i]};
    end
    vecs[16] = '{4'd15, 1'b0, 4'd7,  24'h6F776B};
    vecs[17] = '{4'd15, 1'b0, 4'd0,  24'h0D0E0D};
    vecs[18] = '{4'd6,  1'b0, 4'd15, 24'hD04648};

    rst_n = 1'b0; pix_valid = 1'b0; pix_index = '0; blank = 1'b0; fade = 4'd15;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset_pix", pix_word(), 32'h0);
    chk("reset_rd", rd_word(), 32'h0);
    rst_n = 1'b1;

    // Back-to-back stream; each pixel's fade is driven one cycle later, when it reaches stage 2.
    for (int s = 0; s < N + 2; s++) begin
      @(negedge clk);
      if (s >= 2) chk($sformatf("stream_%0d", s - 2), pix_word(), {7'd0, 1'b1, vecs[s - 2].exp_rgb});
      if (s < N) begin
        pix_valid = 1'b1; pix_index = vecs[s].index; blank = vecs[s].blank;
      end else begin
        pix_valid = 1'b0; blank = 1'b0;
      end
      fade = (s >= 1 && s - 1 < N) ? vecs[s - 1].fade : 4'd15;
    end
    @(negedge clk);
    chk("stream_drain", 32'(out_valid), 32'h0);

    // Write then readback, then pixel through the new entry.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 24'h112233;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd3; pix_valid = 1'b1; pix_index = 4'd3;
    @(negedge clk);
    chk("readback_3", rd_word(), {7'd0, 1'b1, 24'h112233});
    rd_en = 1'b0; pix_valid = 1'b0;
    @(negedge clk);
    chk("readback_hold", rd_word(), {7'd0, 1'b0, 24'h112233});
    chk("pix_3_new", pix_word(), {7'd0, 1'b1, 24'h112233});

    // Same-cycle write/read/lookup of entry 5 sees old data; next lookup sees new.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 24'hFFFFFF;
    rd_en = 1'b1; rd_addr = 4'd5; pix_valid = 1'b1; pix_index = 4'd5;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    chk("collide_rd", rd_word(), {7'd0, 1'b1, 24'h346524});
    @(negedge clk);
    pix_valid = 1'b0;
    chk("collide_pix_old", pix_word(), {7'd0, 1'b1, 24'h346524});
    @(negedge clk);
    chk("collide_pix_new", pix_word(), {7'd0, 1'b1, 24'hFFFFFF});

    // Reset with pixels in flight and a modified entry.
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 24'h000000; pix_valid = 1'b1; pix_index = 4'd0;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    chk("inflight_pix", pix_word(), {7'd0, 1'b1, 24'h140C1C});
    #2 rst_n = 1'b0;
    #1 chk("reset_async_pix", pix_word(), 32'h0);
    @(negedge clk);
    pix_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_valid", 32'(out_valid), 32'h0);
    rd_en = 1'b1; rd_addr = 4'd2;
    @(negedge clk);
    rd_en = 1'b0;
    chk("post_reset_entry2", rd_word(), {7'd0, 1'b1, 24'h30346D});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
